pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Program-counter generation stage that sits directly downstream of the branch controller.
- Consumes the branch controller's next-PC select code and its two candidate targets (pc + imm, rs1 + imm).
- Owns the architectural PC register, the instruction-fetch request handshake, interrupt entry/return, and pipeline flush generation.
- Drives the instruction memory address and feeds the PC back to the branch controller and decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IRQ_VECTOR, 32'h0000_1C00, handler entry address taken on interrupt.
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  downstream hazard; freeze PC and fetch.
- br_valid  in  1  branch controller outputs are valid this cycle (resolving instruction in EX).
- npc_mux_sel  in  2  next-PC select: 00 PLUS4, 01 PC_OFFSET, 10 REG_OFFSET, 11 INTERRUPT (reserved; treated as PLUS4 if driven).
- pc_offset  in  32  branch/JAL target.
- reg_offset  in  32  JALR target.
- irq  in  1  level interrupt request.
- mret  in  1  return-from-handler pulse.
- if_ready  in  1  instruction memory accepted if_addr and returned the instruction this cycle.
- pc  out  32  current PC register.
- if_req  out  1  fetch request.
- if_addr  out  32  fetch address, equal to pc.
- flush  out  1  one-cycle pulse: squash IF/ID contents.
- epc  out  32  saved return address.
- in_handler  out  1  interrupt handler active; further irq masked.
- misalign  out  1  one-cycle pulse: redirect target had nonzero bit 1.

Behaviour:
- Reset values: pc=RESET_PC, epc=0, in_handler=0, flush=0, misalign=0, state=BOOT, if_req=0.
- FSM states:
  - BOOT: if_req=0; always goes to FETCH next cycle.
  - FETCH: if_req=1.
  - HOLD: if_req=0, entered while stall=1; returns to FETCH on the first cycle with stall=0.
- Event priority each cycle: rst > irq entry > mret > redirect > stall > sequential advance.
- irq entry:
  - Condition: irq=1, in_handler=0, state != BOOT.
  - Actions: epc <= pc; pc <= IRQ_VECTOR; in_handler <= 1; flush pulses next cycle; state <= FETCH.
  - Overrides stall.
- mret:
  - Condition: mret=1 and in_handler=1.
  - Actions: pc <= epc; in_handler <= 0; flush pulses; state <= FETCH.
  - mret with in_handler=0 is ignored.
- Redirect:
  - Condition: br_valid=1 and npc_mux_sel in {01, 10}.
  - Target: pc_offset (01) or reg_offset with bit 0 cleared (10). Bits [1:0] of the loaded target are forced to 0.
  - misalign pulses if bit 1 of the selected target is 1.
  - flush pulses the following cycle.
  - Any outstanding fetch is abandoned: that cycle's if_ready is ignored. State <= FETCH even if stall=1, because the redirect wins over stall.
- Sequential advance: in FETCH with stall=0 and if_ready=1, pc <= pc + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
- Stall: in FETCH with stall=1, pc is held; if_ready that cycle is ignored; state <= HOLD.
- No if_ready in FETCH: pc is held and if_req stays high. There is no timeout.
- Latency: redirect, irq, or mret at cycle N puts the new pc and if_addr at N+1, with flush=1 during N+1 only.
- A new event in N+1 is honoured normally; flush then stays high in N+2.
- rst asserted mid-operation wins over every other input in the same cycle.

Decomposition:
- Shared package holds:
  - npc select codes: PLUS4=2'b00, PC_OFFSET=2'b01, REG_OFFSET=2'b10, INTERRUPT=2'b11. These are the same values the branch controller already emits; both blocks import them from here.
  - FSM state encodings.
  - Default RESET_PC and IRQ_VECTOR.
- One natural sub-module: pc_target_sel. Combinational; picks the target, clears LSBs, computes misalign. Its test is self-contained.

Test Plan:
- Reset then if_ready=1 every cycle -> pc reads 0 (BOOT), 0, 4, 8, 12; if_req=0 in the first cycle only.
- At pc=0x10, br_valid=1, sel=01, pc_offset=0x40 -> next cycle pc=0x40, flush=1 for exactly 1 cycle, misalign=0.
- sel=10, reg_offset=0x0000_0103 -> pc=0x100, misalign=1 for 1 cycle.
- stall=1 for 3 cycles at pc=0x20 with if_ready=1 -> pc stays 0x20, if_req=0 during HOLD; resumes 0x24 after the first unstalled accepted fetch.
- irq=1 at pc=0x30 with simultaneous redirect -> pc=0x1C00, epc=0x30, in_handler=1; a second irq is ignored; mret -> pc=0x30, in_handler=0.
- pc=32'hFFFF_FFFC, if_ready=1 -> pc=0; rst asserted during HOLD -> pc=RESET_PC and state=BOOT next cycle.

Source files
------------

// File: rtl/pc_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen_pkg
// Description : Shared next-PC select codes, PC FSM state encoding and
//               default reset/interrupt addresses for the PC generation stage.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_gen_pkg;

    // Same encoding the branch controller emits on npc_mux_sel.
    typedef enum logic [1:0] {
        NPC_PLUS4      = 2'b00,
        NPC_PC_OFFSET  = 2'b01,
        NPC_REG_OFFSET = 2'b10,
        NPC_INTERRUPT  = 2'b11
    } npc_sel_e;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HOLD  = 2'b10
    } pc_state_e;

    localparam logic [31:0] c_reset_pc_default   = 32'h0000_0000;
    localparam logic [31:0] c_irq_vector_default = 32'h0000_1C00;

endpackage : pc_gen_pkg
`default_nettype wire

// File: rtl/pc_gen_target_sel.sv
`default_nettype none
// ============================================================================
// Module      : pc_target_sel
// Description : Combinational redirect decode: picks the branch/JALR target,
//               word-aligns it and flags a target with bit 1 set.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_target_sel
    import pc_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_br_valid,
    input  logic [1:0]      i_npc_mux_sel,
    input  logic [XLEN-1:0] i_pc_offset,
    input  logic [XLEN-1:0] i_reg_offset,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_target,
    output logic            o_misalign
);

    logic [XLEN-1:1] w_raw;
    logic            w_unused;

    // Bit 0 never reaches the PC: JALR clears it and alignment forces it low.
    always_comb begin
        w_raw      = i_pc_offset[XLEN-1:1];
        o_redirect = 1'b0;
        case (i_npc_mux_sel)
            NPC_PC_OFFSET: begin
                w_raw      = i_pc_offset[XLEN-1:1];
                o_redirect = i_br_valid;
            end
            NPC_REG_OFFSET: begin
                w_raw      = i_reg_offset[XLEN-1:1];
                o_redirect = i_br_valid;
            end
            default: ;
        endcase
    end

    assign o_target   = {w_raw[XLEN-1:2], 2'b00};
    assign o_misalign = o_redirect & w_raw[1];
    assign w_unused   = i_pc_offset[0] ^ i_reg_offset[0];

endmodule : pc_target_sel
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen
// Description : Architectural PC register, fetch request FSM, interrupt
//               entry/return and pipeline flush generation.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int               XLEN       = 32,
    parameter logic [XLEN-1:0]  RESET_PC   = c_reset_pc_default,
    parameter logic [XLEN-1:0]  IRQ_VECTOR = c_irq_vector_default
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            br_valid,
    input  logic [1:0]      npc_mux_sel,
    input  logic [XLEN-1:0] pc_offset,
    input  logic [XLEN-1:0] reg_offset,
    input  logic            irq,
    input  logic            mret,
    input  logic            if_ready,
    output logic [XLEN-1:0] pc,
    output logic            if_req,
    output logic [XLEN-1:0] if_addr,
    output logic            flush,
    output logic [XLEN-1:0] epc,
    output logic            in_handler,
    output logic            misalign
);

    pc_state_e       r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_epc;
    logic            r_in_handler;
    logic            r_flush;
    logic            r_misalign;
    logic            r_if_req;

    logic            w_redirect;
    logic [XLEN-1:0] w_target;
    logic            w_target_misalign;
    logic            w_irq_take;
    logic            w_mret_take;

    pc_target_sel #(
        .XLEN (XLEN)
    ) u_target_sel (
        .i_br_valid    (br_valid),
        .i_npc_mux_sel (npc_mux_sel),
        .i_pc_offset   (pc_offset),
        .i_reg_offset  (reg_offset),
        .o_redirect    (w_redirect),
        .o_target      (w_target),
        .o_misalign    (w_target_misalign)
    );

    assign w_irq_take  = irq && !r_in_handler && (r_state != ST_BOOT);
    assign w_mret_take = mret && r_in_handler;

    // Priority: irq entry > mret > redirect > stall > sequential advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_BOOT;
            r_pc         <= RESET_PC;
            r_epc        <= '0;
            r_in_handler <= 1'b0;
            r_flush      <= 1'b0;
            r_misalign   <= 1'b0;
            r_if_req     <= 1'b0;
        end else begin
            r_flush    <= 1'b0;
            r_misalign <= 1'b0;
            if (w_irq_take) begin
                r_epc        <= r_pc;
                r_pc         <= IRQ_VECTOR;
                r_in_handler <= 1'b1;
                r_flush      <= 1'b1;
                r_state      <= ST_FETCH;
                r_if_req     <= 1'b1;
            end else if (w_mret_take) begin
                r_pc         <= r_epc;
                r_in_handler <= 1'b0;
                r_flush      <= 1'b1;
                r_state      <= ST_FETCH;
                r_if_req     <= 1'b1;
            end else if (w_redirect) begin
                // Any in-flight fetch is dropped; if_ready is ignored here.
                r_pc       <= w_target;
                r_flush    <= 1'b1;
                r_misalign <= w_target_misalign;
                r_state    <= ST_FETCH;
                r_if_req   <= 1'b1;
            end else begin
                case (r_state)
                    ST_BOOT: begin
                        r_state  <= ST_FETCH;
                        r_if_req <= 1'b1;
                    end
                    ST_FETCH: begin
                        if (stall) begin
                            r_state  <= ST_HOLD;
                            r_if_req <= 1'b0;
                        end else if (if_ready) begin
                            r_pc <= r_pc + XLEN'(4);
                        end
                    end
                    ST_HOLD: begin
                        if (!stall) begin
                            r_state  <= ST_FETCH;
                            r_if_req <= 1'b1;
                        end
                    end
                    default: begin
                        r_state  <= ST_BOOT;
                        r_if_req <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pc         = r_pc;
    assign if_addr    = r_pc;
    assign if_req     = r_if_req;
    assign flush      = r_flush;
    assign epc        = r_epc;
    assign in_handler = r_in_handler;
    assign misalign   = r_misalign;

endmodule : pc_gen
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_gen
// Description : Self-checking bench for pc_gen: directed scenarios plus
//               randomized traffic compared against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

    localparam logic [31:0] c_reset_pc   = 32'h0000_0000;
    localparam logic [31:0] c_irq_vector = 32'h0000_1C00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br_valid = 1'b0;
    logic [1:0]  npc_mux_sel = 2'b00;
    logic [31:0] pc_offset = '0;
    logic [31:0] reg_offset = '0;
    logic        irq = 1'b0;
    logic        mret = 1'b0;
    logic        if_ready = 1'b0;
    logic [31:0] pc;
    logic        if_req;
    logic [31:0] if_addr;
    logic        flush;
    logic [31:0] epc;
    logic        in_handler;
    logic        misalign;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    pc_gen #(
        .XLEN       (32),
        .RESET_PC   (c_reset_pc),
        .IRQ_VECTOR (c_irq_vector)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .br_valid    (br_valid),
        .npc_mux_sel (npc_mux_sel),
        .pc_offset   (pc_offset),
        .reg_offset  (reg_offset),
        .irq         (irq),
        .mret        (mret),
        .if_ready    (if_ready),
        .pc          (pc),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .flush       (flush),
        .epc         (epc),
        .in_handler  (in_handler),
        .misalign    (misalign)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: fetching / holding / booting tracked as plain flags.
    logic [31:0] m_pc, m_epc;
    bit          m_inh, m_flush, m_mis, m_boot, m_hold;

    always @(posedge clk) begin
        if (rst) begin
            m_pc = c_reset_pc; m_epc = 0; m_inh = 0;
            m_flush = 0; m_mis = 0; m_boot = 1; m_hold = 0;
        end else begin
            logic [31:0] tgt;
            bit nf, nm;
            tgt = (npc_mux_sel == 2'b01) ? pc_offset : reg_offset;
            nf = 0; nm = 0;
            if (irq && !m_inh && !m_boot) begin
                m_epc = m_pc; m_pc = c_irq_vector; m_inh = 1; nf = 1;
                m_boot = 0; m_hold = 0;
            end else if (mret && m_inh) begin
                m_pc = m_epc; m_inh = 0; nf = 1; m_boot = 0; m_hold = 0;
            end else if (br_valid && (npc_mux_sel == 2'b01 || npc_mux_sel == 2'b10)) begin
                m_pc = tgt & 32'hFFFF_FFFC; nm = tgt[1]; nf = 1;
                m_boot = 0; m_hold = 0;
            end else if (m_boot) begin
                m_boot = 0;
            end else if (m_hold) begin
                if (!stall) m_hold = 0;
            end else if (stall) begin
                m_hold = 1;
            end else if (if_ready) begin
                m_pc = m_pc + 32'd4;
            end
            m_flush = nf; m_mis = nm;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("pc", pc, m_pc);
            chk("if_addr", if_addr, m_pc);
            chk("if_req", {31'b0, if_req}, {31'b0, !m_boot && !m_hold});
            chk("flush", {31'b0, flush}, {31'b0, m_flush});
            chk("epc", epc, m_epc);
            chk("in_handler", {31'b0, in_handler}, {31'b0, m_inh});
            chk("misalign", {31'b0, misalign}, {31'b0, m_mis});
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic redirect(input logic [1:0] sel, input logic [31:0] off);
        br_valid = 1'b1; npc_mux_sel = sel;
        if (sel == 2'b01) pc_offset = off; else reg_offset = off;
        tick();
        br_valid = 1'b0; npc_mux_sel = 2'b00;
    endtask

    initial begin
        rst = 1'b1;
        tick(); tick();
        check_en = 1'b1;
        rst = 1'b0; if_ready = 1'b1;
        chk("boot_pc", pc, 32'h0);
        chk("boot_if_req", {31'b0, if_req}, 32'h0);
        tick(); chk("seq_pc0", pc, 32'h0); chk("seq_if_req", {31'b0, if_req}, 32'h1);
        tick(); chk("seq_pc4", pc, 32'h4);
        tick(); chk("seq_pc8", pc, 32'h8);
        tick(); chk("seq_pc12", pc, 32'hC);
        tick(); chk("seq_pc16", pc, 32'h10);

        redirect(2'b01, 32'h40);
        chk("jal_pc", pc, 32'h40); chk("jal_flush", {31'b0, flush}, 32'h1);
        chk("jal_misalign", {31'b0, misalign}, 32'h0);
        if_ready = 1'b0;
        tick(); chk("jal_flush_drop", {31'b0, flush}, 32'h0); chk("jal_hold_pc", pc, 32'h40);

        redirect(2'b10, 32'h0000_0103);
        chk("jalr_pc", pc, 32'h100); chk("jalr_misalign", {31'b0, misalign}, 32'h1);
        tick(); chk("jalr_misalign_drop", {31'b0, misalign}, 32'h0);

        redirect(2'b01, 32'h20);
        stall = 1'b1; if_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); chk("stall_pc", pc, 32'h20); chk("stall_if_req", {31'b0, if_req}, 32'h0);
        end
        stall = 1'b0;
        tick(); chk("unstall_pc", pc, 32'h20); chk("unstall_if_req", {31'b0, if_req}, 32'h1);
        tick(); chk("resume_pc", pc, 32'h24);

        if_ready = 1'b0;
        redirect(2'b01, 32'h30);
        irq = 1'b1; br_valid = 1'b1; npc_mux_sel = 2'b01; pc_offset = 32'h80;
        tick(); br_valid = 1'b0; npc_mux_sel = 2'b00;
        chk("irq_pc", pc, 32'h1C00); chk("irq_epc", epc, 32'h30);
        chk("irq_in_handler", {31'b0, in_handler}, 32'h1);
        tick(); chk("irq_masked_pc", pc, 32'h1C00); chk("irq_masked_epc", epc, 32'h30);
        irq = 1'b0; mret = 1'b1;
        tick(); mret = 1'b0;
        chk("mret_pc", pc, 32'h30); chk("mret_in_handler", {31'b0, in_handler}, 32'h0);

        redirect(2'b01, 32'hFFFF_FFFC);
        if_ready = 1'b1;
        tick(); chk("wrap_pc", pc, 32'h0);
        stall = 1'b1;
        tick(); chk("hold_if_req", {31'b0, if_req}, 32'h0);
        rst = 1'b1;
        tick(); chk("rst_hold_pc", pc, c_reset_pc); chk("rst_hold_if_req", {31'b0, if_req}, 32'h0);
        rst = 1'b0; stall = 1'b0;
        tick(); chk("post_rst_if_req", {31'b0, if_req}, 32'h1);

        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 99) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            if_ready    = $urandom_range(0, 1) == 1;
            br_valid    = ($urandom_range(0, 7) == 0);
            npc_mux_sel = 2'($urandom_range(0, 3));
            pc_offset   = $urandom;
            reg_offset  = $urandom;
            irq         = ($urandom_range(0, 15) == 0);
            mret        = ($urandom_range(0, 11) == 0);
            tick();
        end

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pc_gen
`default_nettype wire
